// File: rtl/mesh_ruche_stitch_reg_if.sv
// ============================================================================
//  Module      : mesh_ruche_stitch_reg_if
//  Description : Bundle of every link that the stitch fabric joins. It holds
//                the tile-side mesh/ruche buses and the array-boundary
//                mesh/ruche buses. The names follow the stitch block's point
//                of view: *_i is consumed by the stitch block and *_o is
//                produced by it.
//                  slave  : the stitch block (reads *_i, drives *_o)
//                  master : the tile array and its boundary (drives *_i)
//                Mesh direction index : W=1, E=2, N=3, S=4
//                Ruche side index     : W=1, E=2
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mesh_ruche_stitch_reg_if #(
    parameter int width_p        = 8,
    parameter int ruche_width_p  = 8,
    parameter int x_max_p        = 3,
    parameter int y_max_p        = 2,
    parameter int ruche_factor_p = 3
) ();

    // Tile mesh links: [row][col][dir]
    logic [width_p-1:0]       outs_i       [y_max_p][x_max_p][4:1];
    logic [width_p-1:0]       ins_o        [y_max_p][x_max_p][4:1];
    // Boundary mesh links, west/east: [side][row]
    logic [width_p-1:0]       hor_i        [2:1][y_max_p];
    logic [width_p-1:0]       hor_o        [2:1][y_max_p];
    // Boundary mesh links, north/south: [side][col]
    logic [width_p-1:0]       ver_i        [4:3][x_max_p];
    logic [width_p-1:0]       ver_o        [4:3][x_max_p];
    // Tile ruche links: [row][col][lane][side]
    logic [ruche_width_p-1:0] ruche_outs_i [y_max_p][x_max_p][ruche_factor_p][2:1];
    logic [ruche_width_p-1:0] ruche_ins_o  [y_max_p][x_max_p][ruche_factor_p][2:1];
    // Boundary ruche links: [side][row][lane]
    logic [ruche_width_p-1:0] ruche_i      [2:1][y_max_p][ruche_factor_p];
    logic [ruche_width_p-1:0] ruche_o      [2:1][y_max_p][ruche_factor_p];

    modport slave (
        input  outs_i, hor_i, ver_i, ruche_outs_i, ruche_i,
        output ins_o,  hor_o, ver_o, ruche_ins_o,  ruche_o
    );

    modport master (
        output outs_i, hor_i, ver_i, ruche_outs_i, ruche_i,
        input  ins_o,  hor_o, ver_o, ruche_ins_o,  ruche_o
    );

endinterface

`default_nettype wire

// File: rtl/mesh_ruche_stitch_reg.sv
// ============================================================================
//  Module      : mesh_ruche_stitch_reg
//  Description : Wiring fabric for an x_max_p by y_max_p tile array. It joins
//                each tile's mesh links and half-ruche-X links to its
//                neighbours or to the array boundary. Only the east edge is
//                retimed by one register stage. Every other path is pure
//                wiring.
//  Ports       : clk_i    - single clock
//                reset_i  - synchronous, active-low reset (east registers)
//                link_if  - mesh_ruche_stitch_reg_if.slave carrying
//                           outs_i/ins_o, hor_i/hor_o, ver_i/ver_o,
//                           ruche_outs_i/ruche_ins_o, ruche_i/ruche_o
//  Options     : MESH_STITCH_RUCHE_INVERT_EN - when defined and
//                ruche_factor_p is even, ruche hops from odd source lanes
//                carry inverted data. This applies to interior hops and to
//                both east registered paths. West-edge ruche is never
//                inverted.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mesh_ruche_stitch_reg #(
    parameter int width_p        = 8,
    parameter int ruche_width_p  = 8,
    parameter int x_max_p        = 3,
    parameter int y_max_p        = 2,
    parameter int ruche_factor_p = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    mesh_ruche_stitch_reg_if.slave   link_if
);

    localparam int c_W = 1;
    localparam int c_E = 2;
    localparam int c_N = 3;
    localparam int c_S = 4;
    localparam int c_R = ruche_factor_p;

`ifdef MESH_STITCH_RUCHE_INVERT_EN
    // Alternate-stage inverting repeaters only line up with an even lane count.
    localparam bit c_INV_EN = ((ruche_factor_p % 2) == 0);
`else
    localparam bit c_INV_EN = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // East-edge retiming registers.
    // The ruche registers are indexed by destination lane, so the rotation
    // and any inversion happen on the _d side, before the flop.
    // ------------------------------------------------------------------------
    logic [width_p-1:0]       he_out_d [y_max_p];
    logic [width_p-1:0]       he_out_q [y_max_p];
    logic [width_p-1:0]       he_in_d  [y_max_p];
    logic [width_p-1:0]       he_in_q  [y_max_p];
    logic [ruche_width_p-1:0] ro_e_d   [y_max_p][ruche_factor_p];
    logic [ruche_width_p-1:0] ro_e_q   [y_max_p][ruche_factor_p];
    logic [ruche_width_p-1:0] ri_e_d   [y_max_p][ruche_factor_p];
    logic [ruche_width_p-1:0] ri_e_q   [y_max_p][ruche_factor_p];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int r = 0; r < y_max_p; r++) begin
                he_out_q[r] <= '0;
                he_in_q[r]  <= '0;
                for (int l = 0; l < ruche_factor_p; l++) begin
                    ro_e_q[r][l] <= '0;
                    ri_e_q[r][l] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < y_max_p; r++) begin
                he_out_q[r] <= he_out_d[r];
                he_in_q[r]  <= he_in_d[r];
                for (int l = 0; l < ruche_factor_p; l++) begin
                    ro_e_q[r][l] <= ro_e_d[r][l];
                    ri_e_q[r][l] <= ri_e_d[r][l];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Mesh links, one tile at a time. Each direction takes either the
    // neighbour's facing output or the boundary. With a single row or
    // column, both sides fall through to the boundary branch.
    // ------------------------------------------------------------------------
    for (genvar r = 0; r < y_max_p; r++) begin : g_mrow
        for (genvar c = 0; c < x_max_p; c++) begin : g_mcol
            if (c > 0) begin : g_w_int
                assign link_if.ins_o[r][c][c_W] = link_if.outs_i[r][c-1][c_E];
            end else begin : g_w_edge
                assign link_if.ins_o[r][c][c_W] = link_if.hor_i[c_W][r];
            end

            if (c < x_max_p - 1) begin : g_e_int
                assign link_if.ins_o[r][c][c_E] = link_if.outs_i[r][c+1][c_W];
            end else begin : g_e_edge
                assign link_if.ins_o[r][c][c_E] = he_in_q[r];
            end

            if (r > 0) begin : g_n_int
                assign link_if.ins_o[r][c][c_N] = link_if.outs_i[r-1][c][c_S];
            end else begin : g_n_edge
                assign link_if.ins_o[r][c][c_N] = link_if.ver_i[c_N][c];
            end

            if (r < y_max_p - 1) begin : g_s_int
                assign link_if.ins_o[r][c][c_S] = link_if.outs_i[r+1][c][c_N];
            end else begin : g_s_edge
                assign link_if.ins_o[r][c][c_S] = link_if.ver_i[c_S][c];
            end
        end

        // West boundary is direct. East boundary goes through the registers.
        assign he_out_d[r]             = link_if.outs_i[r][x_max_p-1][c_E];
        assign he_in_d[r]              = link_if.hor_i[c_E][r];
        assign link_if.hor_o[c_W][r]   = link_if.outs_i[r][0][c_W];
        assign link_if.hor_o[c_E][r]   = he_out_q[r];
    end

    for (genvar c = 0; c < x_max_p; c++) begin : g_vcol
        assign link_if.ver_o[c_N][c] = link_if.outs_i[0][c][c_N];
        assign link_if.ver_o[c_S][c] = link_if.outs_i[y_max_p-1][c][c_S];
    end

    // ------------------------------------------------------------------------
    // Ruche links. Each eastward hop moves lane l to lane l+1, and each
    // westward hop moves lane l to lane l-1 (mod R). For every destination
    // lane, exactly one source lane feeds it, so every output element has a
    // single driver. The mask is all ones only for odd source lanes with
    // inversion enabled. Otherwise it is zero and the XOR is plain wiring.
    // ------------------------------------------------------------------------
    for (genvar r = 0; r < y_max_p; r++) begin : g_rrow
        for (genvar l = 0; l < ruche_factor_p; l++) begin : g_lane
            localparam int c_UP = (l + 1) % c_R;
            localparam int c_DN = (l + c_R - 1) % c_R;
            localparam logic [ruche_width_p-1:0] c_MASK =
                {ruche_width_p{c_INV_EN && ((l % 2) == 1)}};

            // West edge: direct, no rotation, never inverted.
            assign link_if.ruche_o[c_W][r][l]       = link_if.ruche_outs_i[r][0][l][c_W];
            assign link_if.ruche_ins_o[r][0][l][c_W] = link_if.ruche_i[c_W][r][l];

            // East edge: rotate and (optionally) invert before the register.
            assign ro_e_d[r][c_UP] = link_if.ruche_outs_i[r][x_max_p-1][l][c_E] ^ c_MASK;
            assign ri_e_d[r][c_DN] = link_if.ruche_i[c_E][r][l] ^ c_MASK;
            assign link_if.ruche_o[c_E][r][l]                 = ro_e_q[r][l];
            assign link_if.ruche_ins_o[r][x_max_p-1][l][c_E]  = ri_e_q[r][l];

            // Interior hops between column c and c+1.
            for (genvar c = 0; c < x_max_p - 1; c++) begin : g_hop
                assign link_if.ruche_ins_o[r][c+1][c_UP][c_W] =
                    link_if.ruche_outs_i[r][c][l][c_E] ^ c_MASK;
                assign link_if.ruche_ins_o[r][c][c_DN][c_E] =
                    link_if.ruche_outs_i[r][c+1][l][c_W] ^ c_MASK;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mesh_ruche_stitch_reg.sv
`default_nettype none

module tb_mesh_ruche_stitch_reg;

    localparam int DW = 8;
    localparam int RW = 8;
    localparam int XM = 3;
    localparam int YM = 2;
    localparam int RF = 3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mesh_ruche_stitch_reg_if #(
        .width_p(DW), .ruche_width_p(RW), .x_max_p(XM), .y_max_p(YM), .ruche_factor_p(RF)
    ) bus ();

    mesh_ruche_stitch_reg #(
        .width_p(DW), .ruche_width_p(RW), .x_max_p(XM), .y_max_p(YM), .ruche_factor_p(RF)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .link_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A ruche hop from an odd source lane is inverted only under the option
    // and only when the lane count is even.
    function automatic logic [RW-1:0] hop(input logic [RW-1:0] v, input int lane);
`ifdef MESH_STITCH_RUCHE_INVERT_EN
        if ((RF % 2 == 0) && (lane % 2 == 1)) return ~v;
`endif
        return v;
    endfunction

    // Values the east edge presented at the last clock edge (zero after reset).
    logic [DW-1:0] m_he_out [YM];
    logic [DW-1:0] m_he_in  [YM];
    logic [RW-1:0] m_roe    [YM][RF];  // by source lane, after hop
    logic [RW-1:0] m_rie    [YM][RF];

    always @(posedge clk) begin
        for (int r = 0; r < YM; r++) begin
            m_he_out[r] <= rst_n ? bus.outs_i[r][XM-1][2] : '0;
            m_he_in[r]  <= rst_n ? bus.hor_i[2][r] : '0;
            for (int l = 0; l < RF; l++) begin
                m_roe[r][l] <= rst_n ? hop(bus.ruche_outs_i[r][XM-1][l][2], l) : '0;
                m_rie[r][l] <= rst_n ? hop(bus.ruche_i[2][r][l], l) : '0;
            end
        end
    end

    function automatic logic [DW-1:0] exp_ins(input int r, input int c, input int d);
        case (d)
            1: return (c > 0)    ? bus.outs_i[r][c-1][2] : bus.hor_i[1][r];
            2: return (c < XM-1) ? bus.outs_i[r][c+1][1] : m_he_in[r];
            3: return (r > 0)    ? bus.outs_i[r-1][c][4] : bus.ver_i[3][c];
            default: return (r < YM-1) ? bus.outs_i[r+1][c][3] : bus.ver_i[4][c];
        endcase
    endfunction

    function automatic logic [RW-1:0] exp_rins(input int r, input int c, input int k, input int s);
        int src;
        if (s == 1) begin
            src = (k + RF - 1) % RF;   // lane that rotates up into k
            return (c == 0) ? bus.ruche_i[1][r][k] : hop(bus.ruche_outs_i[r][c-1][src][2], src);
        end
        src = (k + 1) % RF;            // lane that rotates down into k
        return (c < XM-1) ? hop(bus.ruche_outs_i[r][c+1][src][1], src) : m_rie[r][src];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] actual=%02h required=%02h", tag, idx, act, exp);
        end
    endtask

    task automatic check_all();
        for (int r = 0; r < YM; r++) begin
            for (int c = 0; c < XM; c++) begin
                for (int d = 1; d <= 4; d++)
                    chk("ins", r*100+c*10+d, bus.ins_o[r][c][d], exp_ins(r, c, d));
                for (int k = 0; k < RF; k++)
                    for (int s = 1; s <= 2; s++)
                        chk("rins", r*1000+c*100+k*10+s, bus.ruche_ins_o[r][c][k][s], exp_rins(r, c, k, s));
            end
            chk("horW", r, bus.hor_o[1][r], bus.outs_i[r][0][1]);
            chk("horE", r, bus.hor_o[2][r], m_he_out[r]);
            for (int k = 0; k < RF; k++) begin
                chk("roW", r*10+k, bus.ruche_o[1][r][k], bus.ruche_outs_i[r][0][k][1]);
                chk("roE", r*10+k, bus.ruche_o[2][r][k], m_roe[r][(k + RF - 1) % RF]);
            end
        end
        for (int c = 0; c < XM; c++) begin
            chk("verN", c, bus.ver_o[3][c], bus.outs_i[0][c][3]);
            chk("verS", c, bus.ver_o[4][c], bus.outs_i[YM-1][c][4]);
        end
    endtask

    task automatic set_inputs(input bit rnd);
        for (int r = 0; r < YM; r++)
            for (int c = 0; c < XM; c++) begin
                for (int d = 1; d <= 4; d++) bus.outs_i[r][c][d] = rnd ? DW'($urandom) : '0;
                for (int l = 0; l < RF; l++)
                    for (int s = 1; s <= 2; s++) bus.ruche_outs_i[r][c][l][s] = rnd ? RW'($urandom) : '0;
            end
        for (int s = 1; s <= 2; s++)
            for (int r = 0; r < YM; r++) begin
                bus.hor_i[s][r] = rnd ? DW'($urandom) : '0;
                for (int l = 0; l < RF; l++) bus.ruche_i[s][r][l] = rnd ? RW'($urandom) : '0;
            end
        for (int s = 3; s <= 4; s++)
            for (int c = 0; c < XM; c++) bus.ver_i[s][c] = rnd ? DW'($urandom) : '0;
    endtask

    task automatic set_east(input logic [7:0] v);
        for (int r = 0; r < YM; r++) begin
            bus.outs_i[r][XM-1][2] = v;
            bus.hor_i[2][r] = v;
            for (int l = 0; l < RF; l++) begin
                bus.ruche_outs_i[r][XM-1][l][2] = v;
                bus.ruche_i[2][r][l] = v;
            end
        end
    endtask

    task automatic chk_east(input string tag, input logic [7:0] v);
        for (int r = 0; r < YM; r++) begin
            chk({tag, "_horE"}, r, bus.hor_o[2][r], v);
            chk({tag, "_insE"}, r, bus.ins_o[r][XM-1][2], v);
            for (int k = 0; k < RF; k++) begin
                chk({tag, "_roE"}, r*10+k, bus.ruche_o[2][r][k], v);
                chk({tag, "_rinsE"}, r*10+k, bus.ruche_ins_o[r][XM-1][k][2], v);
            end
        end
    endtask

    // ip/op: 0 mesh tile, 1 hor, 2 ver, 3 ruche tile, 4 ruche boundary
    typedef struct {
        int ip; int a; int b; int c; int d; logic [7:0] val;
        int op; int e; int f; int g; int h; logic [7:0] exp;
        int lat;
    } vec_t;

    task automatic poke(input int ip, input int a, input int b, input int c, input int d, input logic [7:0] v);
        case (ip)
            0: bus.outs_i[a][b][c] = v;
            1: bus.hor_i[a][b] = v;
            2: bus.ver_i[a][b] = v;
            3: bus.ruche_outs_i[a][b][c][d] = v;
            default: bus.ruche_i[a][b][c] = v;
        endcase
    endtask

    function automatic logic [7:0] rd(input int op, input int e, input int f, input int g, input int h);
        case (op)
            0: return bus.ins_o[e][f][g];
            1: return bus.hor_o[e][f];
            2: return bus.ver_o[e][f];
            3: return bus.ruche_ins_o[e][f][g][h];
            default: return bus.ruche_o[e][f][g];
        endcase
    endfunction

    vec_t vecs [19];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0]  = '{0,0,0,2,0,8'hA5, 0,0,1,1,0,8'hA5, 0};
        vecs[1]  = '{0,0,1,4,0,8'h3C, 0,1,1,3,0,8'h3C, 0};
        vecs[2]  = '{1,1,1,0,0,8'h11, 0,1,0,1,0,8'h11, 0};
        vecs[3]  = '{2,4,2,0,0,8'h22, 0,1,2,4,0,8'h22, 0};
        vecs[4]  = '{0,0,2,3,0,8'h33, 2,3,2,0,0,8'h33, 0};
        vecs[5]  = '{0,0,2,2,0,8'h5A, 1,2,0,0,0,8'h5A, 1};
        vecs[6]  = '{1,2,1,0,0,8'h77, 0,1,2,2,0,8'h77, 1};
        vecs[7]  = '{3,0,0,2,2,8'hC3, 3,0,1,0,1,8'hC3, 0};
        vecs[8]  = '{3,0,1,0,1,8'h96, 3,0,0,2,2,8'h96, 0};
        vecs[9]  = '{4,2,0,0,0,8'h44, 3,0,2,2,2,8'h44, 1};
        vecs[10] = '{3,1,2,1,2,8'h5F, 4,2,1,2,0,8'h5F, 1};
        vecs[11] = '{3,1,0,2,1,8'hE1, 4,1,1,2,0,8'hE1, 0};
        vecs[12] = '{4,1,1,1,0,8'h9C, 3,1,0,1,1,8'h9C, 0};
        vecs[13] = '{0,1,0,1,0,8'hB4, 1,1,1,0,0,8'hB4, 0};
        vecs[14] = '{2,3,0,0,0,8'hD2, 0,0,0,3,0,8'hD2, 0};
        vecs[15] = '{0,1,2,4,0,8'h6E, 2,4,2,0,0,8'h6E, 0};
        vecs[16] = '{3,1,1,2,2,8'hA1, 3,1,2,0,1,8'hA1, 0};
        vecs[17] = '{3,0,2,1,1,8'h7E, 3,0,1,0,2,8'h7E, 0};
        vecs[18] = '{0,1,1,1,0,8'h4B, 0,1,0,2,0,8'h4B, 0};

        // Reset wins over live east-edge data.
        rst_n = 1'b0;
        set_inputs(1'b0);
        set_east(8'hFF);
        @(posedge clk); #1;
        chk_east("rst0", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            set_inputs(1'b0);
            if (vecs[i].lat == 1) begin
                @(posedge clk);
                @(negedge clk);
            end
            poke(vecs[i].ip, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].val);
            #1;
            if (vecs[i].lat == 0) begin
                chk("vec", i, rd(vecs[i].op, vecs[i].e, vecs[i].f, vecs[i].g, vecs[i].h), vecs[i].exp);
            end else begin
                chk("vec_pre", i, rd(vecs[i].op, vecs[i].e, vecs[i].f, vecs[i].g, vecs[i].h), 8'h00);
                @(posedge clk); #1;
                chk("vec", i, rd(vecs[i].op, vecs[i].e, vecs[i].f, vecs[i].g, vecs[i].h), vecs[i].exp);
            end
        end

        // Mid-stream reset: load FF, then one reset edge clears the registers.
        // Interior paths stay transparent throughout.
        @(negedge clk);
        set_inputs(1'b0);
        set_east(8'hFF);
        @(posedge clk); #1;
        chk_east("load", 8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        bus.outs_i[0][0][2] = 8'hA5;
        #1;
        chk("rst_transp", 0, bus.ins_o[0][1][1], 8'hA5);
        chk("rst_sync", 0, bus.hor_o[2][0], 8'hFF);
        @(posedge clk); #1;
        chk_east("rst1", 8'h00);
        chk("rst_transp", 1, bus.ins_o[0][1][1], 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with occasional reset against the model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            set_inputs(1'b1);
            rst_n = ($urandom_range(0, 11) != 0);
            #1;
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mesh_ruche_stitch_reg.md
Name: mesh_ruche_stitch_reg

Overview:
- Wiring fabric for a 2D tile array of x_max_p by y_max_p tiles. It stitches each tile's per-direction mesh links and half-ruche-X links to their neighbours, or to the array boundary.
- The east-edge links carry a pipeline register (retiming stage); all other connections are combinational.
- Sits between tile instances and the array ports of a compute subarray.

Parameters:
- width_p, 8, bit width of one mesh link bundle.
- ruche_width_p, 8, bit width of one ruche link bundle.
- x_max_p, 3, tiles per row (>=1).
- y_max_p, 2, tiles per column (>=1).
- ruche_factor_p, 3, ruche lanes per tile per direction (>=1).

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-low reset.
- outs_i  in  [y_max_p][x_max_p][S:W][width_p]  tile mesh outputs; direction indices W=1, E=2, N=3, S=4.
- ins_o  out  same shape  tile mesh inputs.
- hor_i  in  [E:W][y_max_p][width_p]  boundary mesh inputs, west/east.
- hor_o  out  [E:W][y_max_p][width_p]  boundary mesh outputs.
- ver_i  in  [S:N][x_max_p][width_p]  boundary mesh inputs, north/south.
- ver_o  out  [S:N][x_max_p][width_p]  boundary mesh outputs.
- ruche_outs_i  in  [y_max_p][x_max_p][ruche_factor_p][E:W][ruche_width_p]  tile ruche outputs.
- ruche_ins_o  out  same shape  tile ruche inputs.
- ruche_i  in  [E:W][y_max_p][ruche_factor_p][ruche_width_p]  boundary ruche inputs.
- ruche_o  out  same shape  boundary ruche outputs.

Behaviour:
- Notation: r = row, c = column, l = lane, R = ruche_factor_p.
- Mesh, combinational, zero latency:
  - ins_o[r][c][W] = outs_i[r][c-1][E] for c>0; hor_i[W][r] at c=0.
  - ins_o[r][c][E] = outs_i[r][c+1][W] for c<x_max_p-1; at the last column it comes from the east input register.
  - ins_o[r][c][N] = outs_i[r-1][c][S] for r>0; ver_i[N][c] at r=0.
  - ins_o[r][c][S] = outs_i[r+1][c][N] for r<y_max_p-1; ver_i[S][c] at the last row.
  - hor_o[W][r] = outs_i[r][0][W].
  - ver_o[N][c] = outs_i[0][c][N].
  - ver_o[S][c] = outs_i[y_max_p-1][c][S].
- East edge, registered, one-cycle latency:
  - Register HE_out captures outs_i[r][x_max_p-1][E] and drives hor_o[E][r].
  - Register HE_in captures hor_i[E][r] and drives ins_o[r][x_max_p-1][E].
- Ruche interior, combinational, lane rotation per hop:
  - For c<x_max_p-1: ruche_ins_o[r][c+1][(l+1)%R][W] = ruche_outs_i[r][c][l][E].
  - For c<x_max_p-1: ruche_ins_o[r][c][(l+R-1)%R][E] = ruche_outs_i[r][c+1][l][W].
- Ruche west edge, direct, no rotation:
  - ruche_o[W][r][l] = ruche_outs_i[r][0][l][W].
  - ruche_ins_o[r][0][l][W] = ruche_i[W][r][l].
- Ruche east edge, rotated and registered, one-cycle latency:
  - ruche_o[E][r][(l+1)%R] is the registered ruche_outs_i[r][x_max_p-1][l][E].
  - ruche_ins_o[r][x_max_p-1][(l+R-1)%R][E] is the registered ruche_i[E][r][l].
- Registers:
  - On a rising clk_i with reset_i=0, all east-edge registers clear to 0.
  - Otherwise they load their input every cycle. There is no enable and no stall.
  - Reset asserted mid-stream clears the registers on that edge; data captured that cycle is lost.
- Only east-edge outputs have a reset value (0). All other outputs follow their inputs combinationally, including during reset.
- Degenerate sizes:
  - x_max_p=1: the single column uses the boundary connections on both W and E.
  - y_max_p=1: the single row uses the boundary connections on both N and S.
  - R=1: rotation is the identity.

Optional Feature:
- Macro MESH_STITCH_RUCHE_INVERT_EN.
- When defined and R is even, every ruche hop whose source lane l is odd carries bitwise-inverted data, matching inverting repeaters on alternate ruche stages. This applies to interior hops and to both registered east-edge paths, with inversion applied before the register. West-edge direct connections are never inverted.
- When undefined, all ruche paths are non-inverting.

Test Plan:
- Mesh interior, x3y2: drive outs_i[0][0][E]=8'hA5 -> ins_o[0][1][W]=8'hA5 in the same cycle. Drive outs_i[0][1][S]=8'h3C -> ins_o[1][1][N]=8'h3C.
- Boundary: hor_i[W][1]=8'h11 -> ins_o[1][0][W]=8'h11 in the same cycle. ver_i[S][2]=8'h22 -> ins_o[1][2][S]=8'h22. outs_i[0][2][N]=8'h33 -> ver_o[N][2]=8'h33.
- East latency: outs_i[0][2][E]=8'h5A at cycle t -> hor_o[E][0]=8'h5A at t+1 and not at t. Likewise hor_i[E][1]=8'h77 -> ins_o[1][2][E]=8'h77 one cycle later.
- Ruche rotation, R=3: ruche_outs_i[0][0][2][E]=8'hC3 -> ruche_ins_o[0][1][0][W]=8'hC3. ruche_outs_i[0][1][0][W]=8'h96 -> ruche_ins_o[0][0][2][E]=8'h96. ruche_i[E][0][0]=8'h44 -> ruche_ins_o[0][2][2][E]=8'h44 after one cycle.
- Reset: load the east registers with 8'hFF, then hold reset_i=0 for one edge -> hor_o[E] and ruche_o[E] read 0. Interior paths remain transparent throughout.
- With MESH_STITCH_RUCHE_INVERT_EN and R=2: ruche_outs_i[0][0][1][E]=8'h0F -> ruche_ins_o[0][1][0][W]=8'hF0. Lane 0 passes uninverted.
